bcd_counter_n: RTL
==================

// Module: bcd_counter_n
// PURPOSE
//  Parametrised N-digit BCD up/down counter with keypad-style serial digit load, run/pause/stop
//  control, prescaled count steps, wrap or saturate mode and per-digit 7-segment outputs.
//  Sits between the keypad front-end (load_val/load strobe) and the board 7-seg displays.
// PARAMETERS
//  DIGITS    4  number of BCD digits (1..8); digit 0 = units, least significant
//  PRESCALE  1  clocks per count step while running (>=1); 1 = step every clock
//  SAT       0  0 = wrap at boundary; 1 = saturate at boundary and enter DONE
// PORTS
//  clock     in   1          system clock, all state on rising edge
//  reset     in   1          asynchronous, active-high; forces IDLE, count 0
//  clear     in   1          synchronous clear: count 0, state IDLE
//  enable    in   1          1 = counting allowed; 0 = return to IDLE (count held)
//  func      in   1          direction: 1 = up, 0 = down
//  stop      in   1          1 = pause while running
//  load      in   1          one-clock strobe: shift load_val in as new units digit
//  load_val  in   4          BCD digit from keypad
//  bcd       out  4*DIGITS   current count, packed BCD
//  seg       out  7*DIGITS   7-seg per digit, active-low, bit order gfedcba, digit 0 at [6:0]
//  tc        out  1          terminal-count pulse / level (see below)
//  state     out  2          00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
// BEHAVIOUR
//  - Reset: bcd=0, seg = all digits "0" (7'b1000000), tc=0, state=IDLE, prescaler=0.
//  - Priority per clock: reset > clear > stop > enable/load > step.
//  - IDLE: enable=1 & stop=0 -> RUN (prescaler cleared). load accepted: count shifts left
//    one digit, load_val enters digit 0, MS digit discarded. load_val>9 ignored.
//  - RUN: prescaler counts 0..PRESCALE-1; step on wrap. stop=1 -> PAUSE, step that cycle
//    suppressed, prescaler held. enable=0 -> IDLE, count held. load ignored.
//  - PAUSE: count and prescaler frozen; stop=0 & enable=1 -> RUN (prescaler resumes);
//    enable=0 -> IDLE. load accepted as in IDLE.
//  - DONE (SAT=1 only): count frozen at boundary, tc=1 level; enable=0 or clear -> IDLE.
//  - Step up: BCD increment with digit carry; step down: BCD decrement with digit borrow.
//  - Boundary: up from all-9s, down from 0. SAT=0: wraps (9..9->0, 0->9..9); tc pulses
//    high one clock, registered, the cycle after the wrapping step. SAT=1: step blocked,
//    count unchanged, state -> DONE, tc=1 while in DONE.
//  - func change in RUN takes effect on the next step; no prescaler reset.
//  - seg and bcd registered together: seg always decodes the current bcd (same cycle).
//  - clear while RUN/PAUSE/DONE: count 0, IDLE, tc=0 next clock, prescaler 0.
//  - Reset mid-count: immediate async return to reset values; no partial step retained.
// CONFIGURATION
//  BCD_CNT_LEADING_BLANK_EN defined: leading-zero digits (all digits above the highest
//   non-zero digit) drive seg=7'b1111111 (blank); digit 0 never blanked.
//  Not defined: every digit always displays its value, including leading zeros.
//  bcd, tc and state identical in both builds.
// TESTING
//  1 reset, load 1,2,3,4 (DIGITS=4) -> bcd=16'h1234, state IDLE; load_val=4'hA -> unchanged.
//  2 bcd=0099, func=1, enable=1, PRESCALE=1 -> after 1 clock bcd=0100; PRESCALE=3 -> step
//    every 3rd clock exactly.
//  3 SAT=0, bcd=9999 up -> 0000, tc high exactly one clock; bcd=0000 down -> 9999, tc pulse.
//  4 SAT=1, bcd=0001 down -> 0000, state DONE, tc=1 held; further clocks no change;
//    enable=0 -> IDLE, tc=0.
//  5 RUN with stop=1 on the step cycle -> no step, PAUSE; stop=0 -> RUN, resumes prescaler;
//    clear during PAUSE -> bcd=0, IDLE.
//  6 BCD_CNT_LEADING_BLANK_EN defined, bcd=0040 -> seg[27:14]=blank, seg[13:7]="4", seg[6:0]="0";
//    bcd=0000 -> only digit 0 lit.

Source files
------------

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with serial keypad load, run/pause/done control and 7-seg outputs.
// Optional build macro BCD_CNT_LEADING_BLANK_EN blanks leading-zero digits on seg.
module bcd_counter_n #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1,
  parameter int SAT      = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  func,
  input  logic                  stop,
  input  logic                  load,
  input  logic [3:0]            load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tc,
  output logic [1:0]            state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  count_q, count_d;
  logic [4*DIGITS-1:0]  stepped, shifted;
  logic [7*DIGITS-1:0]  seg_q, seg_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 tc_q, tc_d;
  logic                 step, at_boundary, carry, load_ok;
  logic [3:0]           digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Ripple BCD increment/decrement; the final carry/borrow marks the boundary (all-9s up, 0 down).
  always_comb begin
    stepped = count_q;
    carry   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (func) begin
          stepped[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
          carry             = (digit == 4'd9);
        end else begin
          stepped[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
          carry             = (digit == 4'd0);
        end
      end
    end
    at_boundary = carry;
  end

  always_comb begin
    shifted      = count_q << 4;
    shifted[3:0] = load_val;
    load_ok      = load && (load_val <= 4'd9);
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    step    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_ok) count_d = shifted;
          if (enable && !stop) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (!enable) begin
            state_d = IDLE;
          end else if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d = '0;
            step    = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (load_ok) count_d = shifted;
          if (!stop) state_d = enable ? RUN : IDLE;
        end
        DONE: begin
          if (!enable) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (step) begin
        if (at_boundary && SAT != 0) begin
          state_d = DONE;
        end else begin
          count_d = stepped;
          tc_d    = at_boundary;
        end
      end
    end
    if (state_d == DONE) tc_d = 1'b1;
  end

  // seg is decoded from the next count so both register on the same edge.
  always_comb begin
`ifdef BCD_CNT_LEADING_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seg_d[7*i +: 7] = seg7(count_d[4*i +: 4]);
`ifdef BCD_CNT_LEADING_BLANK_EN
      if (lead && i != 0 && count_d[4*i +: 4] == 4'd0) seg_d[7*i +: 7] = 7'b1111111;
      if (count_d[4*i +: 4] != 4'd0) lead = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
      seg_q   <= {DIGITS{7'b1000000}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd   = count_q;
  assign seg   = seg_q;
  assign tc    = tc_q;
  assign state = state_q;

endmodule
